// File: rtl/pc_hazard_sequencer.sv
// Front-end PC sequencer: load-use bubbles, branch redirects/flushes, imem-wait freeze.
// Optional HAZARD_PERF_CNT_EN adds hold/flush/load-use event counters.
module pc_hazard_sequencer #(
    parameter int unsigned LOAD_USE_STALL = 1,
    parameter bit          FLUSH_EX_MEM   = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        imem_ready_i,
    input  logic        id_ex_memread_i,
    input  logic [4:0]  id_ex_rt_i,
    input  logic [4:0]  if_id_rs_i,
    input  logic [4:0]  if_id_rt_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic [31:0] pc_plus4_i,
    output logic [31:0] pc_next_o,
    output logic        pc_hold_o,
    output logic        if_id_write_o,
    output logic        if_id_flush_o,
    output logic        id_ex_flush_o,
    output logic        ex_mem_flush_o,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0] stall_cycles_o,
    output logic [31:0] flush_events_o,
    output logic [31:0] loaduse_events_o,
`endif
    output logic [1:0]  state_o
);

    localparam int unsigned CNT_W = 3;
    localparam int unsigned PC_W  = 32;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_WAIT  = 2'b10
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic               pend_valid_q, pend_valid_d;
    logic [PC_W-1:0]    pend_target_q, pend_target_d;

    logic               load_use;
    logic               run_decode;
    logic [PC_W-1:0]    pc_next_c;
    logic               pc_hold_c;
    logic               if_id_write_c;
    logic               if_id_flush_c;
    logic               id_ex_flush_c;
    logic               ex_mem_flush_c;

    assign load_use = id_ex_memread_i && (id_ex_rt_i != 5'd0) &&
                      ((id_ex_rt_i == if_id_rs_i) || (id_ex_rt_i == if_id_rt_i));

    // State register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q       <= ST_RUN;
            stall_cnt_q   <= '0;
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
        end else begin
            state_q       <= state_d;
            stall_cnt_q   <= stall_cnt_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
        end
    end

    // Next-state and front-end control decode.
    always_comb begin
        state_d        = state_q;
        stall_cnt_d    = stall_cnt_q;
        pend_valid_d   = pend_valid_q;
        pend_target_d  = pend_target_q;
        pc_next_c      = '0;
        pc_hold_c      = 1'b1;
        if_id_write_c  = 1'b0;
        if_id_flush_c  = 1'b0;
        id_ex_flush_c  = 1'b0;
        ex_mem_flush_c = 1'b0;
        run_decode     = 1'b0;

        case (state_q)
            ST_RUN: run_decode = 1'b1;
            ST_STALL: begin
                if (branch_taken_i) begin
                    run_decode = 1'b1;
                end else begin
                    id_ex_flush_c = 1'b1;
                    stall_cnt_d   = stall_cnt_q - CNT_W'(1);
                    if (stall_cnt_q == CNT_W'(1)) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_WAIT: begin
                if (branch_taken_i) begin
                    run_decode = 1'b1;
                end else if (!imem_ready_i) begin
                    id_ex_flush_c = 1'b1;
                end else if (pend_valid_q) begin
                    pc_next_c     = pend_target_q;
                    pc_hold_c     = 1'b0;
                    if_id_flush_c = 1'b1;
                    id_ex_flush_c = 1'b1;
                    pend_valid_d  = 1'b0;
                    state_d       = ST_RUN;
                end else begin
                    run_decode = 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase

        if (run_decode) begin
            if (branch_taken_i) begin
                // A branch wins over wait and load-use; newest target replaces any pending one.
                if_id_flush_c  = 1'b1;
                id_ex_flush_c  = 1'b1;
                ex_mem_flush_c = FLUSH_EX_MEM;
                stall_cnt_d    = '0;
                if (imem_ready_i) begin
                    pc_next_c    = branch_target_i;
                    pc_hold_c    = 1'b0;
                    pend_valid_d = 1'b0;
                    state_d      = ST_RUN;
                end else begin
                    pend_valid_d  = 1'b1;
                    pend_target_d = branch_target_i;
                    state_d       = ST_WAIT;
                end
            end else if (!imem_ready_i) begin
                id_ex_flush_c = 1'b1;
                state_d       = ST_WAIT;
            end else if (load_use) begin
                id_ex_flush_c = 1'b1;
                if (LOAD_USE_STALL == 1) begin
                    state_d = ST_RUN;
                end else begin
                    stall_cnt_d = CNT_W'(LOAD_USE_STALL - 1);
                    state_d     = ST_STALL;
                end
            end else begin
                pc_next_c     = pc_plus4_i;
                pc_hold_c     = 1'b0;
                if_id_write_c = 1'b1;
                state_d       = ST_RUN;
            end
        end
    end

    // Outputs are forced to a safe frozen value while reset is asserted.
    assign pc_next_o      = rst_i ? pc_next_c      : '0;
    assign pc_hold_o      = rst_i ? pc_hold_c      : 1'b1;
    assign if_id_write_o  = rst_i ? if_id_write_c  : 1'b0;
    assign if_id_flush_o  = rst_i ? if_id_flush_c  : 1'b0;
    assign id_ex_flush_o  = rst_i ? id_ex_flush_c  : 1'b0;
    assign ex_mem_flush_o = rst_i ? ex_mem_flush_c : 1'b0;
    assign state_o        = rst_i ? state_q        : ST_RUN;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] flush_events_q;
    logic [31:0] loaduse_events_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stall_cycles_q   <= '0;
            flush_events_q   <= '0;
            loaduse_events_q <= '0;
        end else begin
            if (pc_hold_c) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (if_id_flush_c) begin
                flush_events_q <= flush_events_q + 32'd1;
            end
            if (load_use && (state_q == ST_RUN)) begin
                loaduse_events_q <= loaduse_events_q + 32'd1;
            end
        end
    end

    assign stall_cycles_o   = stall_cycles_q;
    assign flush_events_o   = flush_events_q;
    assign loaduse_events_o = loaduse_events_q;
`endif

endmodule

// File: tb/tb_pc_hazard_sequencer.sv
// Scoreboard bench: two sequencer configurations driven by shared random stimulus,
// checked against a rule-level reference model.
module tb_pc_hazard_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_ready;
    logic        memread;
    logic [4:0]  ex_rt;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] pc_plus4;

    logic [31:0] o_next  [2];
    logic        o_hold  [2];
    logic        o_write [2];
    logic        o_ifl   [2];
    logic        o_idl   [2];
    logic        o_exl   [2];
    logic [1:0]  o_state [2];

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_a [3];
    logic [31:0] perf_b [3];
`endif

    always #5 clk = ~clk;

    pc_hazard_sequencer #(.LOAD_USE_STALL(1), .FLUSH_EX_MEM(1'b1)) u_a (
        .clk_i(clk), .rst_i(rst_n), .imem_ready_i(imem_ready),
        .id_ex_memread_i(memread), .id_ex_rt_i(ex_rt), .if_id_rs_i(id_rs), .if_id_rt_i(id_rt),
        .branch_taken_i(br_taken), .branch_target_i(br_target), .pc_plus4_i(pc_plus4),
        .pc_next_o(o_next[0]), .pc_hold_o(o_hold[0]), .if_id_write_o(o_write[0]),
        .if_id_flush_o(o_ifl[0]), .id_ex_flush_o(o_idl[0]), .ex_mem_flush_o(o_exl[0]),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cycles_o(perf_a[0]), .flush_events_o(perf_a[1]), .loaduse_events_o(perf_a[2]),
`endif
        .state_o(o_state[0])
    );

    pc_hazard_sequencer #(.LOAD_USE_STALL(3), .FLUSH_EX_MEM(1'b0)) u_b (
        .clk_i(clk), .rst_i(rst_n), .imem_ready_i(imem_ready),
        .id_ex_memread_i(memread), .id_ex_rt_i(ex_rt), .if_id_rs_i(id_rs), .if_id_rt_i(id_rt),
        .branch_taken_i(br_taken), .branch_target_i(br_target), .pc_plus4_i(pc_plus4),
        .pc_next_o(o_next[1]), .pc_hold_o(o_hold[1]), .if_id_write_o(o_write[1]),
        .if_id_flush_o(o_ifl[1]), .id_ex_flush_o(o_idl[1]), .ex_mem_flush_o(o_exl[1]),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cycles_o(perf_b[0]), .flush_events_o(perf_b[1]), .loaduse_events_o(perf_b[2]),
`endif
        .state_o(o_state[1])
    );

    typedef struct {
        logic [31:0] next;
        logic        hold;
        logic        write;
        logic        ifl;
        logic        idl;
        logic        exl;
        logic [1:0]  st;
        bit          c_next;
        bit          c_write;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int checks   = 0;
    int failures = 0;
    int cyc_no   = 0;

    // Reference model: bubbles still owed, waiting-for-memory flag, pending redirect.
    int          m_lus   [2] = '{1, 3};
    bit          m_fem   [2] = '{1'b1, 1'b0};
    int          m_stall [2];
    bit          m_wait  [2];
    bit          m_pend  [2];
    logic [31:0] m_addr  [2];

    task automatic take_branch(input int k, input logic rdy, input logic [31:0] tg, inout exp_t e);
        e.ifl = 1'b1;
        e.idl = 1'b1;
        e.exl = m_fem[k];
        e.c_write = 1'b0;
        m_stall[k] = 0;
        if (rdy) begin
            e.next = tg;
            e.hold = 1'b0;
            m_pend[k] = 1'b0;
            m_wait[k] = 1'b0;
        end else begin
            m_pend[k] = 1'b1;
            m_addr[k] = tg;
            m_wait[k] = 1'b1;
        end
    endtask

    task automatic run_rules(input int k, input logic rdy, lu, br,
                             input logic [31:0] tg, p4, inout exp_t e);
        if (br) begin
            take_branch(k, rdy, tg, e);
        end else if (!rdy) begin
            e.idl = 1'b1;
            m_wait[k] = 1'b1;
        end else if (lu) begin
            e.idl = 1'b1;
            m_stall[k] = m_lus[k] - 1;
        end else begin
            e.next  = p4;
            e.hold  = 1'b0;
            e.write = 1'b1;
        end
    endtask

    task automatic model_step(input int k, input logic rst, rdy, lu, br,
                              input logic [31:0] tg, p4, output exp_t e);
        e.next = 32'd0; e.hold = 1'b1; e.write = 1'b0;
        e.ifl = 1'b0; e.idl = 1'b0; e.exl = 1'b0; e.st = 2'd0;
        e.c_next = 1'b1; e.c_write = 1'b1;
        if (!rst) begin
            m_stall[k] = 0; m_wait[k] = 1'b0; m_pend[k] = 1'b0; m_addr[k] = 32'd0;
            return;
        end
        e.st = m_wait[k] ? 2'd2 : ((m_stall[k] > 0) ? 2'd1 : 2'd0);
        if (m_wait[k]) begin
            if (br) begin
                take_branch(k, rdy, tg, e);
            end else if (!rdy) begin
                e.idl = 1'b1;
            end else if (m_pend[k]) begin
                e.next = m_addr[k];
                e.hold = 1'b0;
                e.ifl  = 1'b1;
                e.idl  = 1'b1;
                e.c_write = 1'b0;
                m_pend[k] = 1'b0;
                m_wait[k] = 1'b0;
            end else begin
                m_wait[k] = 1'b0;
                run_rules(k, rdy, lu, br, tg, p4, e);
            end
        end else if (m_stall[k] > 0) begin
            if (br) begin
                take_branch(k, rdy, tg, e);
            end else begin
                e.idl = 1'b1;
                m_stall[k] = m_stall[k] - 1;
            end
        end else begin
            run_rules(k, rdy, lu, br, tg, p4, e);
        end
        if (e.hold) e.c_next = 1'b0;
    endtask

    // Drive one cycle of inputs just after the edge and queue the expected response.
    task automatic cyc(input logic rst, rdy, mr, input logic [4:0] rt, rs, rt2,
                       input logic br, input logic [31:0] tg, p4);
        exp_t e;
        logic lu;
        @(posedge clk);
        #1;
        rst_n = rst; imem_ready = rdy; memread = mr; ex_rt = rt; id_rs = rs; id_rt = rt2;
        br_taken = br; br_target = tg; pc_plus4 = p4;
        lu = mr && (rt != 5'd0) && ((rt == rs) || (rt == rt2));
        model_step(0, rst, rdy, lu, br, tg, p4, e);
        q0.push_back(e);
        model_step(1, rst, rdy, lu, br, tg, p4, e);
        q1.push_back(e);
    endtask

    task automatic chk(input string nm, input int k, input logic [31:0] act, exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s inst=%0d cycle=%0d actual=%h expected=%h", nm, k, cyc_no, act, exp_v);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare mid-cycle against the queue.
    always @(negedge clk) begin
        exp_t e;
        cyc_no++;
        for (int k = 0; k < 2; k++) begin
            if ((k == 0) ? (q0.size() > 0) : (q1.size() > 0)) begin
                e = (k == 0) ? q0.pop_front() : q1.pop_front();
                chk("pc_hold", k, 32'(o_hold[k]), 32'(e.hold));
                chk("id_ex_flush", k, 32'(o_idl[k]), 32'(e.idl));
                chk("if_id_flush", k, 32'(o_ifl[k]), 32'(e.ifl));
                chk("ex_mem_flush", k, 32'(o_exl[k]), 32'(e.exl));
                chk("state", k, 32'(o_state[k]), 32'(e.st));
                if (e.c_next) chk("pc_next", k, o_next[k], e.next);
                if (e.c_write) chk("if_id_write", k, 32'(o_write[k]), 32'(e.write));
            end
        end
    end

    initial begin
        rst_n = 1'b0; imem_ready = 1'b1; memread = 1'b0; ex_rt = 5'd0; id_rs = 5'd0;
        id_rt = 5'd0; br_taken = 1'b0; br_target = 32'd0; pc_plus4 = 32'd0;

        repeat (3) cyc(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h4);
        cyc(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h4);
        // Load-use on r8, then quiet cycles to observe the bubble count.
        cyc(1'b1, 1'b1, 1'b1, 5'd8, 5'd8, 5'd3, 1'b0, 32'h0, 32'h8);
        repeat (4) cyc(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h8);
        // r0 never creates a hazard.
        cyc(1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 32'hC);
        // Branch beats a simultaneous load-use.
        cyc(1'b1, 1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 32'h40, 32'h10);
        cyc(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h44);
        // Two redirects during a memory wait: the newest one is applied.
        cyc(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 32'h80, 32'h48);
        cyc(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h48);
        cyc(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 32'hC0, 32'h48);
        cyc(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h48);
        cyc(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h48);
        repeat (2) cyc(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 32'hC4);
        // Load-use followed by a branch mid-stall, then reset during a wait.
        cyc(1'b1, 1'b1, 1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 32'h0, 32'h100);
        cyc(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 32'h200, 32'h104);
        cyc(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 32'h300, 32'h204);
        cyc(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h204);
        cyc(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h4);

        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) != 0),
                ($urandom_range(0, 99) < 75),
                ($urandom_range(0, 99) < 35),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                ($urandom_range(0, 99) < 12),
                $urandom, $urandom);
        end
        cyc(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h4);

        for (int w = 0; w < 10 && (q0.size() > 0 || q1.size() > 0); w++) @(posedge clk);
        checks++;
        if (q0.size() > 0 || q1.size() > 0) begin
            failures++;
            $display("FAIL drain actual=%0d/%0d pending expected=0", q0.size(), q1.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
